// File: rtl/word_tokenizer.sv
// Splits a character stream into space-delimited words and classifies each as BEGIN, END or OTHER.
// The token output is a single register with valid/ready handshake; back-pressure stalls the input.
module word_tokenizer (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic       tok_valid,
    input  logic       tok_ready,
    output logic [1:0] tok_type,
    output logic [7:0] tok_len
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_B,
        S_BE,
        S_BEG,
        S_BEGI,
        S_BEGIN,
        S_E,
        S_EN,
        S_END,
        S_OTHER
    } state_t;

    localparam logic [1:0] TOK_BEGIN = 2'b01;
    localparam logic [1:0] TOK_END   = 2'b10;
    localparam logic [1:0] TOK_OTHER = 2'b11;

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       tok_valid_q, tok_valid_d;
    logic [1:0] tok_type_q, tok_type_d;
    logic [7:0] tok_len_q, tok_len_d;

    logic       accept;
    logic       is_delim;
    logic       flush_act;
    logic       word_end;
    logic [7:0] ch_up;

    always_comb begin
        in_ready  = !tok_valid_q || tok_ready;
        accept    = in_valid && in_ready;
        is_delim  = (in == 8'h20);
        flush_act = flush && in_ready && !accept;
        word_end  = (accept && is_delim) || flush_act;
        ch_up     = ((in >= 8'h61) && (in <= 8'h7A)) ? (in - 8'h20) : in;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        tok_valid_d = tok_valid_q && !tok_ready;
        tok_type_d  = tok_type_q;
        tok_len_d   = tok_len_q;

        if (word_end) begin
            // Delimiters and flushes in IDLE are no-ops: no empty tokens.
            if (state_q != S_IDLE) begin
                tok_valid_d = 1'b1;
                tok_len_d   = count_q;
                case (state_q)
                    S_BEGIN: tok_type_d = TOK_BEGIN;
                    S_END:   tok_type_d = TOK_END;
                    default: tok_type_d = TOK_OTHER;
                endcase
                state_d = S_IDLE;
                count_d = 8'd0;
            end
        end else if (accept) begin
            count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
            state_d = S_OTHER;
            case (state_q)
                S_IDLE: begin
                    if (ch_up == "B")      state_d = S_B;
                    else if (ch_up == "E") state_d = S_E;
                end
                S_B:    if (ch_up == "E") state_d = S_BE;
                S_BE:   if (ch_up == "G") state_d = S_BEG;
                S_BEG:  if (ch_up == "I") state_d = S_BEGI;
                S_BEGI: if (ch_up == "N") state_d = S_BEGIN;
                S_E:    if (ch_up == "N") state_d = S_EN;
                S_EN:   if (ch_up == "D") state_d = S_END;
                default: state_d = S_OTHER;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= 8'd0;
            tok_valid_q <= 1'b0;
            tok_type_q  <= 2'b00;
            tok_len_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            tok_valid_q <= tok_valid_d;
            tok_type_q  <= tok_type_d;
            tok_len_q   <= tok_len_d;
        end
    end

    assign tok_valid = tok_valid_q;
    assign tok_type  = tok_type_q;
    assign tok_len   = tok_len_q;

endmodule

// File: tb/tb_word_tokenizer.sv
// Self-checking bench for word_tokenizer: directed scenarios followed by randomized traffic,
// compared every cycle against a word-level reference model.
module tb_word_tokenizer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_ch;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic       tok_valid;
    logic       tok_ready;
    logic [1:0] tok_type;
    logic [7:0] tok_len;

    always #5 clk = ~clk;

    word_tokenizer dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_ch),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .tok_valid (tok_valid),
        .tok_ready (tok_ready),
        .tok_type  (tok_type),
        .tok_len   (tok_len)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the current word as bytes plus the expected output register.
    int           m_cnt = 0;
    byte unsigned m_w[$];
    bit           m_tv = 1'b0;
    logic [1:0]   m_tt = 2'b00;
    logic [7:0]   m_tl = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic byte unsigned fold(input byte unsigned b);
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
        return b;
    endfunction

    function automatic bit word_is(input string key);
        if (m_cnt != key.len()) return 1'b0;
        for (int i = 0; i < key.len(); i++)
            if (fold(m_w[i]) != key.getc(i)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 32'(tok_valid), 32'(m_tv));
        chk({tag, ".type"},  32'(tok_type),  32'(m_tt));
        chk({tag, ".len"},   32'(tok_len),   32'(m_tl));
    endtask

    task automatic step(input bit iv, input byte unsigned ch, input bit fl, input bit tr, input string tag);
        bit exp_rdy;
        bit acc;
        bit term;
        reset     = 1'b0;
        in_valid  = iv;
        in_ch     = ch;
        flush     = fl;
        tok_ready = tr;
        #1;
        exp_rdy = !m_tv || tr;
        chk({tag, ".rdy"}, 32'(in_ready), 32'(exp_rdy));
        acc  = iv && exp_rdy;
        term = (acc && ch == 8'h20) || (fl && exp_rdy && !acc);
        if (term && m_cnt > 0) begin
            m_tv = 1'b1;
            if (word_is("BEGIN"))    m_tt = 2'b01;
            else if (word_is("END")) m_tt = 2'b10;
            else                     m_tt = 2'b11;
            m_tl  = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
            m_cnt = 0;
            m_w.delete();
        end else begin
            if (tr) m_tv = 1'b0;
            if (acc && ch != 8'h20) begin
                m_cnt++;
                if (m_w.size() < 8) m_w.push_back(ch);
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_ch     = 8'h00;
        flush     = 1'b0;
        tok_ready = 1'b0;
        @(posedge clk);
        #1;
        m_cnt = 0;
        m_w.delete();
        m_tv = 1'b0;
        m_tt = 2'b00;
        m_tl = 8'd0;
        reset = 1'b0;
        check_outputs(tag);
        #1;
        chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    endtask

    task automatic send(input string s, input bit tr, input string tag);
        for (int i = 0; i < s.len(); i++)
            step(1'b1, s.getc(i), 1'b0, tr, tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 8'h00, 1'b0, 1'b1, tag);
    endtask

    initial begin
        string alpha;
        string words[4];
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_ch     = 8'h00;
        flush     = 1'b0;
        tok_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset("rst0");

        send("bEgIn ", 1'b1, "begin");
        idle("begin_after");
        idle("begin_after2");

        send("End  beginE endx ", 1'b1, "mix");
        idle("mix_after");

        send("ab ", 1'b0, "stall");
        repeat (3) step(1'b1, "b", 1'b0, 1'b0, "stall_hold");
        step(1'b1, "b", 1'b0, 1'b1, "stall_go");
        step(1'b1, " ", 1'b0, 1'b1, "stall_word");
        idle("stall_after");

        send("beg", 1'b1, "fl_beg");
        step(1'b0, 8'h00, 1'b1, 1'b1, "fl_beg_flush");
        send("end", 1'b1, "fl_end");
        step(1'b0, 8'h00, 1'b1, 1'b1, "fl_end_flush");
        step(1'b0, 8'h00, 1'b1, 1'b1, "fl_idle");
        step(1'b0, 8'h00, 1'b1, 1'b1, "fl_idle2");
        send("x", 1'b1, "fl_char");
        step(1'b1, "y", 1'b1, 1'b1, "fl_with_char");
        step(1'b1, " ", 1'b0, 1'b1, "fl_char_end");
        idle("fl_after");

        repeat (300) step(1'b1, "x", 1'b0, 1'b1, "sat");
        step(1'b1, " ", 1'b0, 1'b1, "sat_end");
        idle("sat_after");

        send("begi", 1'b1, "rst_pre");
        do_reset("rst_mid");
        send("n ", 1'b1, "rst_post");
        idle("rst_after");

        alpha    = "bBeEgGiInNdD";
        words[0] = "begin";
        words[1] = "END";
        words[2] = "bEgIn";
        words[3] = "end";
        for (int it = 0; it < 2500; it++) begin
            int r;
            byte unsigned ch;
            r = $urandom_range(0, 9);
            if (r < 7)      ch = alpha.getc($urandom_range(0, alpha.len() - 1));
            else if (r < 9) ch = 8'h20;
            else            ch = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_rst");
            end else if ($urandom_range(0, 29) == 0) begin
                send({words[$urandom_range(0, 3)], " "}, 1'($urandom_range(0, 3) != 0), "rnd_word");
            end else begin
                step(1'($urandom_range(0, 3) != 0), ch, 1'($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 3) != 0), "rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/word_tokenizer.md
WORD_TOKENIZER -- requirements
Module: word_tokenizer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below (clock and reset first).
REQ-002 `clk` SHALL be an input, 1 bit wide: the single clock; all state updates on the rising edge.
REQ-003 `reset` SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-004 `in` SHALL be an input, 8 bits wide: an ASCII character.
REQ-005 `in_valid` SHALL be an input, 1 bit wide: `in` holds a character this cycle.
REQ-006 `in_ready` SHALL be an output, 1 bit wide: the block can accept a character or flush this cycle.
REQ-007 `flush` SHALL be an input, 1 bit wide: end-of-stream request that terminates any pending word.
REQ-008 `tok_valid` SHALL be an output, 1 bit wide: the token output register holds an unconsumed token.
REQ-009 `tok_ready` SHALL be an input, 1 bit wide: the downstream checker consumes the token this cycle.
REQ-010 `tok_type` SHALL be an output, 2 bits wide: 2'b01 = BEGIN, 2'b10 = END, 2'b11 = OTHER, 2'b00 = none.
REQ-011 `tok_len` SHALL be an output, 8 bits wide: character count of the emitted word.

Function
REQ-012 in_ready SHALL equal (!tok_valid || tok_ready), combinationally.
REQ-013 A character SHALL be accepted only when in_valid && in_ready; when not accepted, `in` SHALL be ignored and all state SHALL hold.
REQ-014 The delimiter SHALL be 8'h20 (space); every other byte value SHALL be a word character.
REQ-015 Letter matching SHALL be case-insensitive: bytes 8'h41-8'h5A and 8'h61-8'h7A SHALL be folded to upper case; non-letters SHALL NOT be folded.
REQ-016 The FSM states SHALL be IDLE, B, BE, BEG, BEGI, BEGIN, E, EN, END, OTHER.
REQ-017 From IDLE, an accepted 'B' SHALL go to B, an accepted 'E' SHALL go to E, and any other non-delimiter SHALL go to OTHER.
REQ-018 Each accepted character matching the next letter of "BEGIN" or "END" SHALL advance the FSM one state (B->BE->BEG->BEGI->BEGIN; E->EN->END).
REQ-019 Any non-matching non-delimiter, including any character accepted in BEGIN or END, SHALL go to OTHER; OTHER SHALL be absorbing until a delimiter.
REQ-020 The length counter SHALL increment per accepted word character and SHALL saturate at 255.
REQ-021 On an accepted delimiter in state BEGIN, tok_type SHALL be loaded with 01; in state END, with 10; in any other non-IDLE state, with 11.
REQ-022 On the same delimiter, tok_len SHALL be loaded with the count and tok_valid SHALL be set on the next edge (latency 1 cycle); the FSM SHALL return to IDLE and the count SHALL clear.
REQ-023 A delimiter accepted in IDLE (consecutive or leading spaces) SHALL emit no token and SHALL leave the state unchanged.
REQ-024 flush SHALL act only when in_ready is high and no character is accepted that cycle.
REQ-025 An acting flush SHALL behave exactly as a delimiter; flush in IDLE SHALL be a no-op.
REQ-026 A flush coinciding with an accepted character SHALL be ignored.
REQ-027 tok_valid, tok_type and tok_len SHALL hold stable while tok_valid && !tok_ready.
REQ-028 tok_valid SHALL clear on an edge where tok_ready is high, unless a new token is loaded in that same cycle, in which case the new token SHALL replace the old one and tok_valid SHALL stay 1 (back-to-back throughput).
REQ-029 tok_type and tok_len SHALL retain their last values while tok_valid = 0.

Reset
REQ-030 While reset is high at a rising edge, the block SHALL set state = IDLE, count = 0, tok_valid = 0, tok_type = 2'b00 and tok_len = 0.
REQ-031 Reset SHALL take priority over all inputs.
REQ-032 A pending or partially matched word SHALL be discarded by reset, with no token emitted.
REQ-033 in_ready SHALL be 1 in the cycle after reset, provided tok_ready is ignored (tok_valid = 0).

Verification
REQ-034 The bench SHALL cover: tok_ready = 1, stream "bEgIn " -> one token, type 01, len 5, tok_valid high exactly one cycle, one cycle after the space.
REQ-035 The bench SHALL cover: stream "End  beginE endx " -> tokens 10/3, 11/6, 11/4, and nothing for the double space.
REQ-036 The bench SHALL cover: tok_ready = 0 after "ab " -> tok_valid = 1, type 11, len 2 held; in_ready = 0; a subsequent 'b' with in_valid held is not accepted until tok_ready = 1.
REQ-037 The bench SHALL cover: "beg" then flush -> token 11/3; "end" then flush -> 10/3; flush in IDLE -> no token; flush with in_valid = 1 -> character taken, flush ignored.
REQ-038 The bench SHALL cover: 300 'x' then space -> token 11, len 255.
REQ-039 The bench SHALL cover: "begi", reset for one cycle, then "n " -> token 11/1 (prefix discarded) and no token for the pre-reset prefix.
